// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divide unit between NUM_REQ requesters.
// One operation is in flight at a time; the result is routed back to the requester that issued it.
module div_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [XLEN*NUM_REQ-1:0] req_rs1,
  input  logic [XLEN*NUM_REQ-1:0] req_rs2,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [XLEN-1:0]         resp_data,
  output logic                    div_valid,
  input  logic                    div_ready,
  output logic [1:0]              div_op,
  output logic [XLEN-1:0]         div_rs1,
  output logic [XLEN-1:0]         div_rs2,
  input  logic                    div_done,
  input  logic [XLEN-1:0]         div_result,
  output logic                    busy
);

  localparam int GW = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      win_idx;
  logic [GW-1:0]      next_ptr;
  logic               have_win;
  logic               accept;
  logic               grant_resp_ready;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [1:0]         win_op;
  logic [XLEN-1:0]    win_rs1;
  logic [XLEN-1:0]    win_rs2;

  // Scan from rr_ptr with wrap; the first requester found holding req_valid wins.
  always_comb begin
    int cand;
    have_win = 1'b0;
    win_idx  = '0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!have_win && cand == j && req_valid[j]) begin
          have_win = 1'b1;
          win_idx  = GW'(j);
        end
      end
    end
  end

  assign accept   = reset && (state == IDLE) && have_win;
  assign next_ptr = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    win_op    = '0;
    win_rs1   = '0;
    win_rs2   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = accept && (win_idx == GW'(j));
      if (win_idx == GW'(j)) begin
        win_op  = req_op[2*j +: 2];
        win_rs1 = req_rs1[XLEN*j +: XLEN];
        win_rs2 = req_rs2[XLEN*j +: XLEN];
      end
    end
  end

  // Only the granted requester's resp_ready can retire the response.
  always_comb begin
    grant_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_onehot[j] = (grant == GW'(j));
    end
    grant_resp_ready = |(resp_ready & grant_onehot);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      div_op     <= '0;
      div_rs1    <= '0;
      div_rs2    <= '0;
      resp_data  <= '0;
      div_valid  <= 1'b0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_op    <= win_op;
            div_rs1   <= win_rs1;
            div_rs2   <= win_rs2;
            grant     <= win_idx;
            rr_ptr    <= next_ptr;
            div_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (div_ready) begin
            div_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (div_done) begin
            resp_data  <= div_result;
            resp_valid <= grant_onehot;
            state      <= RESP;
          end
        end
        RESP: begin
          if (grant_resp_ready) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_resp_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(resp_valid));
  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_div_valid_state: assert property (@(posedge clk) disable iff (!reset) div_valid |-> state == ISSUE);
  a_busy_state: assert property (@(posedge clk) disable iff (!reset) busy == (state != IDLE));
  a_issue_hold: assert property (@(posedge clk) disable iff (!reset)
    div_valid && !div_ready |=> div_valid && $stable(div_op) && $stable(div_rs1) && $stable(div_rs2));

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for latency, grant order and pass-through data.
module tb_div_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  localparam int PH_NONE   = 0;
  localparam int PH_TO_DIV = 1;
  localparam int PH_IN_DIV = 2;
  localparam int PH_REPORT = 3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [2*NUM_REQ-1:0]    req_op;
  logic [XLEN*NUM_REQ-1:0] req_rs1;
  logic [XLEN*NUM_REQ-1:0] req_rs2;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready = 2'b11;
  logic [XLEN-1:0]         resp_data;
  logic                    div_valid;
  logic                    div_ready = 1'b1;
  logic [1:0]              div_op;
  logic [XLEN-1:0]         div_rs1;
  logic [XLEN-1:0]         div_rs2;
  logic                    div_done;
  logic [XLEN-1:0]         div_result;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  op_t q0[$];
  op_t q1[$];
  logic [NUM_REQ-1:0] drv_taken;

  bit          auto_div  = 1'b1;
  bit          echo_mode = 1'b0;
  int          div_lat   = 3;
  logic [31:0] div_res   = 32'd14;
  int          stray_seq = 0;
  int          stray_done = 0;
  logic [31:0] stray_val = '0;
  int          countdown;
  bit          rsp_hs;
  logic [31:0] rsp_cap;
  logic [31:0] rsp_pend;

  int          m_phase = PH_NONE;
  int          m_owner = 0;
  int          m_ptr   = 0;
  logic [1:0]  m_op    = '0;
  logic [31:0] m_rs1   = '0;
  logic [31:0] m_rs2   = '0;
  logic [31:0] m_data  = '0;
  int          grant_log[$];
  int          resp_owner_log[$];
  logic [31:0] resp_data_log[$];
  logic [NUM_REQ-1:0] prev_rv = '0;

  div_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_op(div_op),
    .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_done(div_done), .div_result(div_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  function automatic int pick_winner();
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (m_ptr + k) % NUM_REQ;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  // Transaction model: an op is taken from the winner, handed to the divider,
  // computed, then reported to its owner until that owner takes it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = PH_NONE;
      m_ptr   = 0;
      m_owner = 0;
      m_op    = '0;
      m_rs1   = '0;
      m_rs2   = '0;
      m_data  = '0;
    end else if (m_phase == PH_NONE) begin
      int w;
      w = pick_winner();
      if (w >= 0) begin
        m_owner = w;
        m_op    = req_op[2*w +: 2];
        m_rs1   = req_rs1[XLEN*w +: XLEN];
        m_rs2   = req_rs2[XLEN*w +: XLEN];
        m_ptr   = (w + 1) % NUM_REQ;
        m_phase = PH_TO_DIV;
        grant_log.push_back(w);
      end
    end else if (m_phase == PH_TO_DIV) begin
      if (div_ready) m_phase = PH_IN_DIV;
    end else if (m_phase == PH_IN_DIV) begin
      if (div_done) begin
        m_data  = div_result;
        m_phase = PH_REPORT;
      end
    end else begin
      if (resp_ready[m_owner]) m_phase = PH_NONE;
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rv;
    int w;
    exp_ready = '0;
    exp_rv    = '0;
    w = pick_winner();
    if (reset === 1'b1 && m_phase == PH_NONE && w >= 0) exp_ready[w] = 1'b1;
    if (m_phase == PH_REPORT) exp_rv[m_owner] = 1'b1;
    check_output("cyc_req_ready", req_ready, exp_ready);
    check_output("cyc_resp_valid", resp_valid, exp_rv);
    check_output("cyc_div_valid", div_valid, m_phase == PH_TO_DIV);
    check_output("cyc_busy", busy, m_phase != PH_NONE);
    check_output("cyc_div_op", div_op, m_op);
    check_output("cyc_div_rs1", div_rs1, m_rs1);
    check_output("cyc_div_rs2", div_rs2, m_rs2);
    check_output("cyc_resp_data", resp_data, m_data);
    if (resp_valid != '0 && prev_rv == '0) begin
      resp_owner_log.push_back(resp_valid[1] ? 1 : 0);
      resp_data_log.push_back(resp_data);
    end
    prev_rv = resp_valid;
  end

  // Requester side: each queue head is presented until it is accepted.
  initial begin
    req_valid = '0;
    req_op    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    forever begin
      @(posedge clk);
      drv_taken = req_valid & req_ready;
      #1;
      if (drv_taken[0] && q0.size() > 0) void'(q0.pop_front());
      if (drv_taken[1] && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1;
        req_op[1:0] = q0[0].op;
        req_rs1[31:0] = q0[0].a;
        req_rs2[31:0] = q0[0].b;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1;
        req_op[3:2] = q1[0].op;
        req_rs1[63:32] = q1[0].a;
        req_rs2[63:32] = q1[0].b;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
  end

  // Divider side: answers div_lat cycles after the issue handshake, plus scripted stray pulses.
  initial begin
    div_done   = 1'b0;
    div_result = '0;
    countdown  = 0;
    rsp_pend   = '0;
    forever begin
      @(posedge clk);
      rsp_hs  = auto_div && reset === 1'b1 && div_valid && div_ready;
      rsp_cap = echo_mode ? div_rs1 : div_res;
      #2;
      div_done = 1'b0;
      if (!reset) countdown = 0;
      if (rsp_hs) begin
        countdown = div_lat;
        rsp_pend  = rsp_cap;
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          div_done   = 1'b1;
          div_result = rsp_pend;
        end
      end
      if (stray_done != stray_seq) begin
        div_done   = 1'b1;
        div_result = stray_val;
        stray_done = stray_seq;
      end
    end
  end

  task automatic wait_for(input string name, input int what, input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick();
      case (what)
        0: ok = (q0.size() == 0 && q1.size() == 0 && req_valid == '0 && busy == 1'b0);
        1: ok = div_valid;
        2: ok = (resp_valid != '0);
        default: ok = (busy && !div_valid);
      endcase
    end
    if (!ok) check_output(name, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_g[4];
    logic [31:0] exp_d[4];
    #1;
    reset = 1'b0;

    // Single divu 100/7 from requester 0, D=3, result 14
    q0.push_back('{op: 2'b01, a: 32'd100, b: 32'd7});
    tick();
    tick();
    check_output("s1_ready_in_reset", req_ready, 2'b00);
    check_output("s1_busy_in_reset", busy, 0);
    reset = 1'b1;
    #1;
    check_output("s1_ready_at_T", req_ready, 2'b01);
    tick();
    check_output("s1_div_valid_T1", div_valid, 1);
    check_output("s1_div_op", div_op, 2'b01);
    check_output("s1_div_rs1", div_rs1, 32'd100);
    check_output("s1_div_rs2", div_rs2, 32'd7);
    tick();
    check_output("s1_div_valid_after_hs", div_valid, 0);
    check_output("s1_busy_wait", busy, 1);
    tick();
    tick();
    check_output("s1_resp_not_yet", resp_valid, 2'b00);
    tick();
    check_output("s1_resp_valid_T5", resp_valid, 2'b01);
    check_output("s1_resp_data_T5", resp_data, 32'd14);
    tick();
    check_output("s1_busy_low_T6", busy, 0);
    check_output("s1_resp_done", resp_valid, 2'b00);

    // Contention from reset release: rem -7/2 on both, divider returns all ones
    reset = 1'b0;
    div_lat = 2;
    div_res = 32'hFFFF_FFFF;
    q0.push_back('{op: 2'b10, a: 32'hFFFF_FFF9, b: 32'd2});
    q1.push_back('{op: 2'b10, a: 32'hFFFF_FFF9, b: 32'd2});
    tick();
    tick();
    grant_log.delete();
    resp_owner_log.delete();
    resp_data_log.delete();
    reset = 1'b1;
    wait_for("s2_timeout", 0, 60);
    check_output("s2_grant_count", grant_log.size(), 2);
    check_output("s2_grant0", grant_log[0], 0);
    check_output("s2_grant1", grant_log[1], 1);
    check_output("s2_resp_order0", resp_owner_log[0], 0);
    check_output("s2_resp_order1", resp_owner_log[1], 1);
    check_output("s2_resp_data0", resp_data_log[0], 32'hFFFF_FFFF);
    check_output("s2_resp_data1", resp_data_log[1], 32'hFFFF_FFFF);
    check_output("s2_ptr_after", m_ptr, 0);

    // Fairness: both keep requesting; the divider echoes the dividend
    echo_mode = 1'b1;
    div_lat = 1;
    grant_log.delete();
    resp_data_log.delete();
    q0.push_back('{op: 2'b01, a: 32'd10, b: 32'd3});
    q0.push_back('{op: 2'b01, a: 32'd20, b: 32'd3});
    q1.push_back('{op: 2'b00, a: 32'd11, b: 32'd3});
    q1.push_back('{op: 2'b00, a: 32'd21, b: 32'd3});
    wait_for("s3_timeout", 0, 100);
    exp_g = '{0, 1, 0, 1};
    exp_d = '{32'd10, 32'd11, 32'd20, 32'd21};
    check_output("s3_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("s3_grant%0d", i), grant_log[i], exp_g[i]);
      check_output($sformatf("s3_data%0d", i), resp_data_log[i], exp_d[i]);
    end

    // Back-pressure on both handshakes, with stray pulses and a withdrawn request
    echo_mode = 1'b0;
    div_res = 32'hDEAD_BEEF;
    div_ready = 1'b0;
    resp_ready = 2'b01;
    grant_log.delete();
    q1.push_back('{op: 2'b11, a: 32'h0000_1234, b: 32'd0});
    wait_for("s4_issue_timeout", 1, 20);
    for (int i = 0; i < 4; i++) begin
      check_output("s4_div_valid_held", div_valid, 1);
      check_output("s4_div_rs1_held", div_rs1, 32'h0000_1234);
      check_output("s4_div_rs2_held", div_rs2, 32'd0);
      check_output("s4_div_op_held", div_op, 2'b11);
      if (i == 0) q0.push_back('{op: 2'b00, a: 32'd99, b: 32'd9});
      if (i == 1) begin
        stray_val = 32'h3333_3333;
        stray_seq++;
      end
      if (i == 2) q0.delete();
      tick();
    end
    div_ready = 1'b1;
    tick();
    wait_for("s4_resp_timeout", 2, 20);
    for (int i = 0; i < 3; i++) begin
      check_output("s4_resp_valid_held", resp_valid, 2'b10);
      check_output("s4_resp_data_held", resp_data, 32'hDEAD_BEEF);
      if (i == 1) begin
        stray_val = 32'h4444_4444;
        stray_seq++;
      end
      tick();
    end
    check_output("s4_resp_after_stray", resp_data, 32'hDEAD_BEEF);
    check_output("s4_still_resp", resp_valid, 2'b10);
    resp_ready = 2'b11;
    tick();
    check_output("s4_resp_released", resp_valid, 2'b00);
    check_output("s4_idle", busy, 0);
    check_output("s4_only_one_grant", grant_log.size(), 1);
    check_output("s4_grant_owner", grant_log[0], 1);

    // Stray pulse while idle
    stray_val = 32'h5555_5555;
    stray_seq++;
    tick();
    tick();
    check_output("s5_busy", busy, 0);
    check_output("s5_resp_valid", resp_valid, 2'b00);
    check_output("s5_resp_data", resp_data, 32'hDEAD_BEEF);

    // Reset during WAIT, then a late result pulse
    auto_div = 1'b0;
    q0.push_back('{op: 2'b01, a: 32'd7, b: 32'd7});
    wait_for("s6_wait_timeout", 3, 20);
    check_output("s6_busy_in_wait", busy, 1);
    reset = 1'b0;
    #1;
    check_output("s6_rst_resp_valid", resp_valid, 2'b00);
    check_output("s6_rst_div_valid", div_valid, 0);
    check_output("s6_rst_resp_data", resp_data, 32'd0);
    check_output("s6_rst_div_op", div_op, 2'b00);
    check_output("s6_rst_div_rs1", div_rs1, 32'd0);
    check_output("s6_rst_div_rs2", div_rs2, 32'd0);
    check_output("s6_rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    stray_val = 32'd5;
    stray_seq++;
    tick();
    tick();
    check_output("s6_no_resp", resp_valid, 2'b00);
    check_output("s6_idle", busy, 0);
    check_output("s6_resp_data_zero", resp_data, 32'd0);
    auto_div = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative divide unit (div/divu/rem/remu) between NUM_REQ requesters, e.g. two executor lanes.
- Accepts one operation at a time with round-robin fairness.
- Issues the operation to the divider, waits for its result, and returns the result to the requester that issued it.
- Sits between the executor lanes and the shared divider; uses the same valid/ready handshake as the rest of the pipeline.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); grant index width GW = 2 bits.
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i presents an operation.
- req_ready  out  NUM_REQ  arbiter accepts from requester i this cycle.
- req_op  in  2*NUM_REQ  per-requester op: 00 div, 01 divu, 10 rem, 11 remu.
- req_rs1  in  XLEN*NUM_REQ  per-requester dividend.
- req_rs2  in  XLEN*NUM_REQ  per-requester divisor.
- resp_valid  out  NUM_REQ  result available for requester i.
- resp_ready  in  NUM_REQ  requester i takes the result.
- resp_data  out  XLEN  result, shared bus, meaningful only under resp_valid.
- div_valid  out  1  operation presented to the divider.
- div_ready  in  1  divider accepts the operation.
- div_op  out  2  latched op.
- div_rs1  out  XLEN  latched dividend.
- div_rs2  out  XLEN  latched divisor.
- div_done  in  1  single-cycle pulse: divider result valid.
- div_result  in  XLEN  divider result, sampled when div_done is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE, rr_ptr = 0.
  - Latched op/rs1/rs2/result = 0, grant = 0.
  - Every output is 0: resp_valid, div_valid, resp_data, div_op, div_rs1, div_rs2, busy.
  - req_ready is 0 while reset is low.
  - Reset may arrive in any state. Any div_done pulse in the first cycle after reset, or while in IDLE, is ignored.
- Arbitration (combinational, IDLE only):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i] = 1 is the winner.
  - req_ready is one-hot at the winner and 0 everywhere in every other state.
  - req_ready does not depend on resp_ready or div_ready.
- Acceptance: req_valid[i] & req_ready[i] at edge T. At that edge:
  - Latch op, rs1, rs2 from slice i; grant = i.
  - rr_ptr = (i+1) mod NUM_REQ.
  - state moves to ISSUE.
- State machine:
  - IDLE: on acceptance, go to ISSUE. Otherwise stay.
  - ISSUE: div_valid = 1, and div_op/div_rs1/div_rs2 are held stable. On div_valid & div_ready, go to WAIT. div_ready may stay low any number of cycles.
  - WAIT: wait for div_done. On div_done, latch div_result into resp_data and go to RESP.
  - RESP: resp_valid[grant] = 1 and all other bits 0; resp_data is held stable. On resp_ready[grant], go to IDLE. resp_ready on non-granted bits is ignored.
- Latency with div_ready = 1 and resp_ready = 1:
  - Accept at T, issue handshake at T+1, result at T+1+D (D = divider latency ≥ 1), response handshake at T+2+D.
  - A new acceptance is possible at T+3+D; there is no same-cycle reuse of IDLE.
- Boundary conditions:
  - Simultaneous requests: only one is served. The losers keep req_valid high, their operands must stay stable, and they are served in round-robin order.
  - A requester that drops req_valid before acceptance loses its turn with no side effect.
  - A div_done pulse in ISSUE is a protocol violation and is ignored.
  - A div_done pulse in RESP is ignored; resp_data is not overwritten.
  - Divide-by-zero and overflow results are whatever div_result carries; the arbiter passes them through unmodified.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Invariants:
  - $onehot0(resp_valid).
  - $onehot0(req_ready).
  - div_valid implies state == ISSUE.
  - busy == (state != IDLE).
  - div_valid, once high, stays high until div_ready with stable operands.

Test Plan:
- Single op: requester 0 sends divu 100/7; divider D=3, div_result=14 -> req_ready[0] at T, div_valid at T+1, resp_valid[0] with resp_data = 14 at T+5, busy low at T+6.
- Contention: both req_valid high from reset release, both ops rem -7/2, divider returns 0xFFFFFFFF -> requester 0 granted first, then 1; resp_valid toggles 01 -> 10 across the two ops; rr_ptr = 0 afterwards.
- Fairness: requester 0 requests continuously, requester 1 also requesting -> grants strictly alternate 0,1,0,1 over 4 ops.
- Back-pressure: div_ready low 4 cycles in ISSUE, then resp_ready[1] low 3 cycles in RESP -> div_valid held with unchanged div_rs1/div_rs2; resp_valid[1] held with resp_data = 0xDEADBEEF stable.
- Reset mid-op: assert reset low during WAIT, release, then pulse div_done = 1 with div_result = 5 -> all outputs stay 0, state IDLE, no resp_valid.
- Stray pulse: div_done high in IDLE and again in RESP -> no state change; resp_data unchanged.
